// File: rtl/delivery_pkg.sv
// Shared encodings and widths for the delivery game round controller.
package delivery_pkg;

    localparam int unsigned PATTERN_W  = 4;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned MAX_ROUNDS = 16;
    localparam int unsigned SCORE_W    = 5;
    localparam int unsigned LIVES_W    = 2;
    localparam int unsigned TIMER_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_LOAD       = 3'd2,
        ST_WAIT_INPUT = 3'd3,
        ST_JUDGE      = 3'd4,
        ST_RELEASE    = 3'd5,
        ST_WIN        = 3'd6,
        ST_LOSE       = 3'd7
    } state_t;

endpackage

// File: rtl/delivery_round_timer.sv
// Per-round tick counter; expire_c flags the tick that exhausts the round budget.
// Only instantiated when DELIVERY_SEQ_TIMEOUT_EN is defined.
module delivery_round_timer
    import delivery_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expire_c
);

    logic [TIMER_W-1:0] count;

    assign expire_c = enable && tick && (count == TIMER_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/delivery_sequencer.sv
// Round controller: fetches each target pattern, judges the answer or timeout, tracks score/lives.
// Round timer built only when DELIVERY_SEQ_TIMEOUT_EN is defined.
module delivery_sequencer
    import delivery_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 8,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned ROUNDS        = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] buttons,
    input  logic                 tick,
    input  logic [PATTERN_W-1:0] rom_data,
    output logic [ADDR_W-1:0]    rom_address,
    output logic [PATTERN_W-1:0] target,
    output logic                 target_valid,
    output logic                 hit,
    output logic                 miss,
    output logic [SCORE_W-1:0]   score,
    output logic [LIVES_W-1:0]   lives,
    output logic                 win,
    output logic                 lose
);

    localparam logic [ADDR_W-1:0]  LAST_INDEX = ADDR_W'(ROUNDS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_ROUNDS);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_W-1:0]      index_next;
    logic [PATTERN_W-1:0]   target_next;
    logic [SCORE_W-1:0]     score_next;
    logic [LIVES_W-1:0]     lives_next;
    logic                   correct;
    logic                   correct_next;
    logic                   hit_next;
    logic                   miss_next;
    logic                   answer_c;
    logic                   expire_c;

    assign answer_c = (buttons != '0);

`ifdef DELIVERY_SEQ_TIMEOUT_EN
    logic timer_clear_c;
    logic timer_enable_c;

    // Timer runs only while waiting with no answer, so an answer always beats a timeout
    assign timer_clear_c  = (state == ST_LOAD);
    assign timer_enable_c = (state == ST_WAIT_INPUT) && !answer_c;

    delivery_round_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_round_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (timer_clear_c),
        .enable   (timer_enable_c),
        .tick     (tick),
        .expire_c (expire_c)
    );
`else
    logic unused_timer;

    assign unused_timer = &{1'b0, tick, TIMER_W'(TIMEOUT_TICKS)};
    assign expire_c     = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_next   = state;
        index_next   = rom_address;
        target_next  = '0;
        score_next   = score;
        lives_next   = lives;
        correct_next = correct;
        hit_next     = 1'b0;
        miss_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                index_next = '0;
                score_next = '0;
                lives_next = LIVES_INIT;
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                target_next = rom_data;
                state_next  = ST_WAIT_INPUT;
            end
            ST_WAIT_INPUT: begin
                if (answer_c) begin
                    correct_next = (buttons == target);
                    state_next   = ST_JUDGE;
                end else if (expire_c) begin
                    correct_next = 1'b0;
                    state_next   = ST_JUDGE;
                end else begin
                    target_next = target;
                end
            end
            ST_JUDGE: begin
                if (correct) begin
                    hit_next = 1'b1;
                    if (score != SCORE_MAX) begin
                        score_next = score + SCORE_W'(1);
                    end
                end else begin
                    miss_next = 1'b1;
                    if (lives != '0) begin
                        lives_next = lives - LIVES_W'(1);
                    end
                end
                if (lives_next == '0) begin
                    state_next = ST_LOSE;
                end else if (rom_address == LAST_INDEX) begin
                    state_next = ST_WIN;
                end else begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // A held answer must be let go before the next round can begin
                if (!answer_c) begin
                    index_next = rom_address + ADDR_W'(1);
                    state_next = ST_FETCH;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start) begin
                    index_next = '0;
                    score_next = '0;
                    lives_next = LIVES_INIT;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rom_address  <= '0;
            target       <= '0;
            target_valid <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            score        <= '0;
            lives        <= LIVES_INIT;
            win          <= 1'b0;
            lose         <= 1'b0;
            correct      <= 1'b0;
        end else begin
            state        <= state_next;
            rom_address  <= index_next;
            target       <= target_next;
            target_valid <= (state_next == ST_WAIT_INPUT);
            hit          <= hit_next;
            miss         <= miss_next;
            score        <= score_next;
            lives        <= lives_next;
            win          <= (state_next == ST_WIN);
            lose         <= (state_next == ST_LOSE);
            correct      <= correct_next;
        end
    end

endmodule

// File: tb/tb_delivery_sequencer.sv
// Bench for delivery_sequencer: a 16-round unit and a 2-round unit against a game-level model.
// Timeout scenario depends on DELIVERY_SEQ_TIMEOUT_EN.
module tb_delivery_sequencer;

    localparam int unsigned LIVES   = 3;
    localparam int unsigned TIMEOUT = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       start_v       [2];
    logic [3:0] buttons_v     [2];
    logic [3:0] rom_data_v    [2];
    logic [3:0] rom_address_v [2];
    logic [3:0] target_v      [2];
    logic       target_valid_v[2];
    logic       hit_v         [2];
    logic       miss_v        [2];
    logic [4:0] score_v       [2];
    logic [1:0] lives_v       [2];
    logic       win_v         [2];
    logic       lose_v        [2];
    logic [3:0] rom_tab       [2][16];

    int checks = 0;
    int errors = 0;

    // Game-level model: round index, score, lives, outcome (0 running, 1 win, 2 lose)
    int m_index [2];
    int m_score [2];
    int m_lives [2];
    int m_over  [2];
    int m_rounds[2] = '{16, 2};

    always #5 clock = ~clock;

    // Registered ROM per unit
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            rom_data_v[k] <= rom_tab[k][rom_address_v[k]];
        end
    end

    delivery_sequencer #(
        .TIMEOUT_TICKS (TIMEOUT),
        .LIVES         (LIVES),
        .ROUNDS        (16)
    ) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start_v[0]),
        .buttons      (buttons_v[0]),
        .tick         (tick),
        .rom_data     (rom_data_v[0]),
        .rom_address  (rom_address_v[0]),
        .target       (target_v[0]),
        .target_valid (target_valid_v[0]),
        .hit          (hit_v[0]),
        .miss         (miss_v[0]),
        .score        (score_v[0]),
        .lives        (lives_v[0]),
        .win          (win_v[0]),
        .lose         (lose_v[0])
    );

    delivery_sequencer #(
        .TIMEOUT_TICKS (TIMEOUT),
        .LIVES         (LIVES),
        .ROUNDS        (2)
    ) u_dut2 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start_v[1]),
        .buttons      (buttons_v[1]),
        .tick         (1'b0),
        .rom_data     (rom_data_v[1]),
        .rom_address  (rom_address_v[1]),
        .target       (target_v[1]),
        .target_valid (target_valid_v[1]),
        .hit          (hit_v[1]),
        .miss         (miss_v[1]),
        .score        (score_v[1]),
        .lives        (lives_v[1]),
        .win          (win_v[1]),
        .lose         (lose_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] wrong(input logic [3:0] t);
        return (t == 4'hF) ? 4'h1 : ~t;
    endfunction

    task automatic model_reset(input int u);
        m_index[u] = 0;
        m_score[u] = 0;
        m_lives[u] = LIVES;
        m_over[u]  = 0;
    endtask

    task automatic check_reset(input int u, input string p);
        chk({p, "_rom_address"}, 32'(rom_address_v[u]), 0);
        chk({p, "_target"}, 32'(target_v[u]), 0);
        chk({p, "_target_valid"}, 32'(target_valid_v[u]), 0);
        chk({p, "_hit"}, 32'(hit_v[u]), 0);
        chk({p, "_miss"}, 32'(miss_v[u]), 0);
        chk({p, "_score"}, 32'(score_v[u]), 0);
        chk({p, "_lives"}, 32'(lives_v[u]), LIVES);
        chk({p, "_win"}, 32'(win_v[u]), 0);
        chk({p, "_lose"}, 32'(lose_v[u]), 0);
    endtask

    task automatic wait_valid(input int u, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!target_valid_v[u] && n < 20);
        chk("valid_seen", 32'(target_valid_v[u]), 1);
    endtask

    task automatic next_round(input int u);
        int n;
        m_index[u]++;
        wait_valid(u, n);
        chk("round_latency", n, 3);
        chk("round_address", 32'(rom_address_v[u]), m_index[u]);
        chk("round_target", 32'(target_v[u]), 32'(rom_tab[u][m_index[u]]));
    endtask

    task automatic start_game(input int u);
        int n;
        start_v[u] = 1'b1;
        @(negedge clock);
        start_v[u] = 1'b0;
        model_reset(u);
        chk("start_address", 32'(rom_address_v[u]), 0);
        chk("start_score", 32'(score_v[u]), 0);
        chk("start_lives", 32'(lives_v[u]), LIVES);
        chk("start_valid_low", 32'(target_valid_v[u]), 0);
        chk("start_win_lose", 32'({win_v[u], lose_v[u]}), 0);
        wait_valid(u, n);
        chk("start_latency", n, 2);
        chk("start_target", 32'(target_v[u]), 32'(rom_tab[u][0]));
    endtask

    // Judge outcome visible in the cycle after JUDGE
    task automatic verify(input int u, input logic [3:0] b);
        bit ok;
        ok = (b == rom_tab[u][m_index[u]]);
        if (ok) m_score[u]++;
        else m_lives[u]--;
        if (m_lives[u] == 0) m_over[u] = 2;
        else if (m_index[u] == m_rounds[u] - 1) m_over[u] = 1;
        chk("hit", 32'(hit_v[u]), 32'(ok));
        chk("miss", 32'(miss_v[u]), 32'(!ok));
        chk("score", 32'(score_v[u]), m_score[u]);
        chk("lives", 32'(lives_v[u]), m_lives[u]);
        chk("win", 32'(win_v[u]), 32'(m_over[u] == 1));
        chk("lose", 32'(lose_v[u]), 32'(m_over[u] == 2));
        chk("target_cleared", 32'({target_valid_v[u], target_v[u]}), 0);
    endtask

    task automatic answer(input int u, input logic [3:0] b, input int hold, input bit with_tick);
        buttons_v[u] = b;
        tick = with_tick;
        @(negedge clock);
        tick = 1'b0;
        chk("judge_no_pulse", 32'({hit_v[u], miss_v[u]}), 0);
        @(negedge clock);
        verify(u, b);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("held_no_rehit", 32'(hit_v[u]), 0);
            chk("held_no_valid", 32'(target_valid_v[u]), 0);
        end
        buttons_v[u] = 4'h0;
        if (m_over[u] == 0) next_round(u);
    endtask

    task automatic tick_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] b;
        reset_n = 1'b0;
        tick    = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_v[u]   = 1'b0;
            buttons_v[u] = 4'h0;
            for (int a = 0; a < 16; a++) rom_tab[u][a] = 4'($urandom_range(1, 15));
            rom_tab[u][0] = 4'b0001;
            rom_tab[u][1] = 4'b0010;
            model_reset(u);
        end
        repeat (2) @(negedge clock);
        check_reset(0, "por");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_valid", 32'(target_valid_v[0]), 0);

        // Game start and round 0
        start_game(0);
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        chk("ignored_start_valid", 32'(target_valid_v[0]), 1);
        chk("ignored_start_address", 32'(rom_address_v[0]), m_index[0]);
        answer(0, 4'b0001, 0, 1'b0);

        // Round 1: no answer, TIMEOUT ticks
        tick_pulses(TIMEOUT);
`ifdef DELIVERY_SEQ_TIMEOUT_EN
        verify(0, 4'h0);
        next_round(0);
`else
        chk("no_timer_valid", 32'(target_valid_v[0]), 1);
        chk("no_timer_miss", 32'(miss_v[0]), 0);
        answer(0, wrong(rom_tab[0][m_index[0]]), 0, 1'b0);
`endif

        // Round 2: answer together with the final tick
        tick_pulses(TIMEOUT - 1);
        answer(0, rom_tab[0][m_index[0]], 0, 1'b1);

        // Random rounds
        for (int r = 0; r < 6 && m_over[0] == 0; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if ($urandom_range(0, 3) != 0) b = rom_tab[0][m_index[0]];
            else b = 4'($urandom_range(1, 15));
            answer(0, b, 0, 1'b0);
        end
        while (m_over[0] == 0) answer(0, wrong(rom_tab[0][m_index[0]]), 0, 1'b0);
        repeat (2) @(negedge clock);
        chk("lose_hold", 32'(lose_v[0]), 1);
        chk("lose_score_hold", 32'(score_v[0]), m_score[0]);

        // Fresh game lost in three wrong rounds, then restart
        start_game(0);
        for (int r = 0; r < 3; r++) answer(0, wrong(rom_tab[0][m_index[0]]), 0, 1'b0);
        chk("three_wrong_lose", 32'(lose_v[0]), 1);
        chk("three_wrong_lives", 32'(lives_v[0]), 0);
        chk("three_wrong_address", 32'(rom_address_v[0]), 2);
        start_game(0);
        answer(0, rom_tab[0][0], 0, 1'b0);

        // Reset asserted during JUDGE
        buttons_v[0] = rom_tab[0][m_index[0]];
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset(0, "mid");
        buttons_v[0] = 4'h0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset(0);
        model_reset(1);
        @(negedge clock);

        // Two-round game with a held answer
        start_game(1);
        answer(1, rom_tab[1][0], 3, 1'b0);
        answer(1, rom_tab[1][1], 0, 1'b0);
        chk("win_final", 32'(win_v[1]), 1);
        chk("win_score", 32'(score_v[1]), 2);
        repeat (2) @(negedge clock);
        chk("win_hold", 32'(win_v[1]), 1);
        chk("win_score_hold", 32'(score_v[1]), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
